// File: rtl/control_sequencer.sv
// SAP-1.5 microcode sequencer: fetch/execute step counter plus sticky HALT.
// Build option ILLEGAL_OPCODE_TRAP_EN traps opcodes A-D into HALT with illegal_op.
module control_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int STEP_WIDTH   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    flag_zero,
    input  logic                    flag_carry,
    output logic                    oe_pc,
    output logic                    load_pc,
    output logic                    pc_enable,
    output logic                    load_mar,
    output logic                    oe_ram,
    output logic                    load_ram,
    output logic                    load_ir,
    output logic                    oe_ir,
    output logic                    load_a,
    output logic                    oe_a,
    output logic                    load_b,
    output logic                    oe_alu,
    output logic                    alu_sub,
    output logic                    load_flags,
    output logic                    load_o,
    output logic                    halt,
`ifdef ILLEGAL_OPCODE_TRAP_EN
    output logic                    illegal_op,
`endif
    output logic [STEP_WIDTH-1:0]   micro_step
);

    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'h1);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDB = OPCODE_WIDTH'(4'h2);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'h3);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'h4);
    localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(4'h5);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(4'h6);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(4'h7);
    localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(4'h8);
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(4'h9);
    localparam logic [OPCODE_WIDTH-1:0] OP_ILO = OPCODE_WIDTH'(4'hA);
    localparam logic [OPCODE_WIDTH-1:0] OP_IHI = OPCODE_WIDTH'(4'hD);
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'hE);
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'hF);

    typedef enum logic [2:0] {
        S_T0   = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t state;
    state_t next_state;
    logic   halt_op;

`ifdef ILLEGAL_OPCODE_TRAP_EN
    logic illegal_opc;
    logic illegal_q;

    assign illegal_opc = (opcode >= OP_ILO) && (opcode <= OP_IHI);
    assign halt_op     = (opcode == OP_HLT) || illegal_opc;

    // Rises on the same edge that enters HALT.
    always_ff @(posedge clk) begin
        if (reset)
            illegal_q <= 1'b0;
        else if (state == S_T2 && illegal_opc)
            illegal_q <= 1'b1;
    end

    assign illegal_op = illegal_q & ~reset;
`else
    assign halt_op = (opcode == OP_HLT);
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_T0;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        oe_pc      = 1'b0;
        load_pc    = 1'b0;
        pc_enable  = 1'b0;
        load_mar   = 1'b0;
        oe_ram     = 1'b0;
        load_ram   = 1'b0;
        load_ir    = 1'b0;
        oe_ir      = 1'b0;
        load_a     = 1'b0;
        oe_a       = 1'b0;
        load_b     = 1'b0;
        oe_alu     = 1'b0;
        alu_sub    = 1'b0;
        load_flags = 1'b0;
        load_o     = 1'b0;
        halt       = 1'b0;
        micro_step = STEP_WIDTH'(state);

        unique case (state)
            S_T0: begin
                oe_pc      = 1'b1;
                load_mar   = 1'b1;
                next_state = S_T1;
            end
            S_T1: begin
                oe_ram     = 1'b1;
                load_ir    = 1'b1;
                pc_enable  = 1'b1;
                next_state = S_T2;
            end
            S_T2: begin
                next_state = S_T0;
                case (opcode)
                    OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_STA: begin
                        oe_ir      = 1'b1;
                        load_mar   = 1'b1;
                        next_state = S_T3;
                    end
                    OP_LDI: begin
                        oe_ir  = 1'b1;
                        load_a = 1'b1;
                    end
                    OP_JMP: begin
                        oe_ir   = 1'b1;
                        load_pc = 1'b1;
                    end
                    OP_JC: begin
                        oe_ir   = flag_carry;
                        load_pc = flag_carry;
                    end
                    OP_JZ: begin
                        oe_ir   = flag_zero;
                        load_pc = flag_zero;
                    end
                    OP_OUT: begin
                        oe_a   = 1'b1;
                        load_o = 1'b1;
                    end
                    default: ;
                endcase
                if (halt_op)
                    next_state = S_HALT;
            end
            S_T3: begin
                next_state = S_T0;
                case (opcode)
                    OP_LDA: begin
                        oe_ram = 1'b1;
                        load_a = 1'b1;
                    end
                    OP_LDB: begin
                        oe_ram = 1'b1;
                        load_b = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        oe_ram     = 1'b1;
                        load_b     = 1'b1;
                        next_state = S_T4;
                    end
                    OP_STA: begin
                        oe_a     = 1'b1;
                        load_ram = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                oe_alu     = 1'b1;
                load_a     = 1'b1;
                load_flags = 1'b1;
                alu_sub    = (opcode == OP_SUB);
                next_state = S_T0;
            end
            S_HALT: begin
                halt       = 1'b1;
                micro_step = '0;
            end
            default: next_state = S_T0;
        endcase

        // Reset kills every strobe of the instruction in flight.
        if (reset) begin
            oe_pc      = 1'b0;
            load_pc    = 1'b0;
            pc_enable  = 1'b0;
            load_mar   = 1'b0;
            oe_ram     = 1'b0;
            load_ram   = 1'b0;
            load_ir    = 1'b0;
            oe_ir      = 1'b0;
            load_a     = 1'b0;
            oe_a       = 1'b0;
            load_b     = 1'b0;
            oe_alu     = 1'b0;
            alu_sub    = 1'b0;
            load_flags = 1'b0;
            load_o     = 1'b0;
            halt       = 1'b0;
            micro_step = '0;
        end
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcode control unit for the SAP-1.5 8-bit computer.
- Sequences fetch/execute for every instruction by driving the bus output-enables and register load strobes of the PC, MAR, RAM, IR, A, B, ALU, flags and output register.
- Decodes the IR opcode nibble plus the Z/C flags.
- Holds a sticky HALT state that the bench's run-until-halt helper watches.

Parameters:
- OPCODE_WIDTH, 4: width of the opcode field taken from IR[7:4].
- STEP_WIDTH, 3: width of the microstep counter; T0..T4 are used.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  OPCODE_WIDTH  IR upper nibble, valid from T2
- flag_zero  input  1  registered Z flag
- flag_carry  input  1  registered C flag
- oe_pc, load_pc, pc_enable  output  1 each  PC drive bus / load from bus / increment
- load_mar  output  1  MAR load from bus
- oe_ram, load_ram  output  1 each  RAM drive bus / write from bus
- load_ir, oe_ir  output  1 each  IR load / drive operand nibble (zero-extended) onto bus
- load_a, oe_a, load_b  output  1 each  A load / A drive / B load
- oe_alu, alu_sub, load_flags  output  1 each  ALU drive / subtract select / latch Z,C
- load_o  output  1  output register load
- halt  output  1  high while in HALT
- micro_step  output  STEP_WIDTH  current step, for debug

Behaviour:
- State: step counter T0..T4 plus a HALT state. All control outputs are combinational from (state, opcode, flags).
- At most one oe_* is high in any cycle.
- Reset:
  - Synchronous. The next state is T0 and HALT clears.
  - While reset is high, all control outputs are forced to 0; halt=0 and micro_step=0.
  - Reset during any step, including HALT, aborts the instruction. No further strobes of that instruction are issued.
- Fetch, common to all opcodes:
  - T0: oe_pc, load_mar.
  - T1: oe_ram, load_ir, pc_enable.
- Execute from T2, by opcode. The step after an instruction's last step is T0.
  - 0 NOP: T2 none. 3 cycles.
  - 1 LDA: T2 oe_ir+load_mar; T3 oe_ram+load_a. 4 cycles.
  - 2 LDB: T2 oe_ir+load_mar; T3 oe_ram+load_b. 4 cycles.
  - 3 ADD: T2 oe_ir+load_mar; T3 oe_ram+load_b; T4 oe_alu+load_a+load_flags, alu_sub=0. 5 cycles.
  - 4 SUB: same as ADD but alu_sub=1 in T4. 5 cycles.
  - 5 STA: T2 oe_ir+load_mar; T3 oe_a+load_ram. 4 cycles.
  - 6 LDI: T2 oe_ir+load_a. 3 cycles.
  - 7 JMP: T2 oe_ir+load_pc. 3 cycles.
  - 8 JC: T2 oe_ir+load_pc only if flag_carry=1, otherwise no strobes. 3 cycles either way.
  - 9 JZ: as JC, using flag_zero. 3 cycles.
  - E OUT: T2 oe_a+load_o. 3 cycles.
  - F HLT: T2 issues no strobes; next state is HALT.
  - A-D: undefined; see Optional Feature.
- Flags are sampled combinationally in T2 only.
- HALT:
  - halt=1 and all controls 0.
  - HALT is sticky; only reset leaves it.
  - micro_step reads 0 in HALT.
- Counter never exceeds T4. No wrap-around beyond the defined sequences.

Optional Feature:
- Macro: ILLEGAL_OPCODE_TRAP_EN.
- Defined: opcodes A-D enter HALT after T2, exactly like HLT. An extra output, illegal_op (1 bit), is set in the same cycle halt rises and cleared only by reset.
- Undefined: opcodes A-D execute as NOP (3 cycles, no strobes). The illegal_op port does not exist.

Test Plan:
- Reset held 2 cycles mid-stream:
  - During reset: all controls 0, halt=0, micro_step=0.
  - First cycle after release: oe_pc=1, load_mar=1.
  - Next cycle: oe_ram, load_ir, pc_enable.
- opcode=1 (LDA): T2 oe_ir+load_mar, T3 oe_ram+load_a. Cycle 5 is T0 again. Full system with RAM image loading 0xAB: A reads 0xAB at halt.
- opcode=3 then opcode=4:
  - T4 asserts oe_alu+load_a+load_flags with alu_sub=0 (ADD) then 1 (SUB).
  - Each instruction takes exactly 5 cycles.
- opcode=8 with flag_carry=0: no load_pc, back to T0 after 3 cycles. With flag_carry=1: T2 oe_ir+load_pc. Repeat for opcode=9 with flag_zero.
- opcode=F: halt=1 from the cycle after T2 and held 20 cycles with every control 0. A reset pulse returns to T0 with halt=0.
- Reset asserted in T3 of ADD: load_a/oe_alu never asserted; next cycle after release is T0. Also opcode=A:
  - Macro defined: halt=1, illegal_op=1.
  - Macro undefined: 3-cycle NOP, then T0.
